// File: rtl/alu_pkg.sv
// Shared definitions for the ALU multi-cycle units (divider and multiplier).
//
// Handshake used by both units toward ALU_all:
//   validIn  - request level. ALU_all raises it with the operands, holds it
//              high while it stalls, and drops it once it sees validOut.
//   validOut - result valid. It is high only while the unit sits in DONE.
//   A new operation needs validIn low for at least one edge between requests.
package alu_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
// Ports:
//   rem_i, quo_i  - current partial remainder and dividend/quotient shifter
//   divisor_i     - divisor magnitude
//   rem_o, quo_o  - remainder and quotient after shifting in one quotient bit
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // rem stays below the divisor, so the shifted value fits in WIDTH+1 bits
  // and the top bit of the difference is a clean borrow/sign flag.
  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle integer divider for DIV/DIVU (restoring, one bit per cycle).
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   validIn           - request level from ALU_all
//   sign              - 1 = signed, 0 = unsigned (sampled at capture)
//   SrcA, SrcB        - dividend, divisor (sampled at capture)
//   validOut          - result valid, only in DONE
//   Hi, Lo            - remainder, quotient; change only in FIX
//
// state | meaning
// IDLE  | waiting for validIn; captures operand magnitudes and sign flags
// CALC  | WIDTH restoring steps, one per edge
// FIX   | sign correction, loads Hi/Lo
// DONE  | result held; validOut raised, leaves when validIn drops
module div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] step_rem, step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (validIn) begin
          quo_d   = (sign && SrcA[WIDTH-1]) ? -SrcA : SrcA;
          dvs_d   = (sign && SrcB[WIDTH-1]) ? -SrcB : SrcB;
          qneg_d  = sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          rneg_d  = sign & SrcA[WIDTH-1];
          dz_d    = (SrcB == '0);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!validIn) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = FIX;
        end
      end
      FIX: begin
        if (!validIn) begin
          state_d = IDLE;
        end else begin
          // With a zero divisor the steps leave quo=all ones and rem=|A|;
          // skipping the quotient negation and re-negating rem yields
          // Lo=all ones, Hi=original dividend in both modes.
          lo_d    = (qneg_q && !dz_q) ? -quo_q : quo_q;
          hi_d    = rneg_q ? -rem_q : rem_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!validIn) state_d = IDLE;
        else          valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
    end
  end

  assign validOut = valid_q;
  assign Hi       = hi_q;
  assign Lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        validIn;
  logic        sign;
  logic [31:0] SrcA, SrcB;
  logic        validOut;
  logic [31:0] Hi, Lo;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .validIn  (validIn),
    .sign     (sign),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .validOut (validOut),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  always #5 clk = ~clk;

  // Issue one request and hold validIn until validOut (bounded).
  // lat = number of edges after the capture edge at which validOut is seen,
  // or -1 on timeout. Returns at the negedge where validIn was just dropped.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic s, output int lat);
    @(negedge clk);
    SrcA = a; SrcB = b; sign = s; validIn = 1'b1;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (validOut === 1'b1) begin
        lat = i - 1;
        break;
      end
    end
    validIn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; validIn = 1'b0; sign = 1'b0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (validOut !== 1'b0) begin n_fail++; $display("FAIL reset_validOut: got %b expected 0", validOut); end
    n_tests++;
    if (Hi !== 32'h0) begin n_fail++; $display("FAIL reset_Hi: got %h expected 00000000", Hi); end
    n_tests++;
    if (Lo !== 32'h0) begin n_fail++; $display("FAIL reset_Lo: got %h expected 00000000", Lo); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned_basic();
    int lat;
    run_div(32'd100, 32'd7, 1'b0, lat);
    n_tests++;
    if (lat !== 34) begin n_fail++; $display("FAIL udiv_latency: got %0d expected 34", lat); end
    n_tests++;
    if (Lo !== 32'd14) begin n_fail++; $display("FAIL udiv_Lo: got %h expected 0000000e", Lo); end
    n_tests++;
    if (Hi !== 32'd2) begin n_fail++; $display("FAIL udiv_Hi: got %h expected 00000002", Hi); end
    @(negedge clk);
    n_tests++;
    if (validOut !== 1'b0) begin n_fail++; $display("FAIL udiv_validOut_fall: got %b expected 0", validOut); end
  endtask

  task automatic test_vectors();
    logic [31:0] va [6]  = '{32'hFFFFFFF9, 32'd7,      32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'h12345678};
    logic [31:0] vb [6]  = '{32'd2,        32'hFFFFFFFE, 32'd1,      32'hFFFFFFFF, 32'h0,        32'h0};
    logic        vs [6]  = '{1'b1,         1'b1,     1'b0,         1'b1,         1'b0,         1'b1};
    logic [31:0] elo [6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ehi [6] = '{32'hFFFFFFFF, 32'd1,    32'h0,        32'h0,        32'h12345678, 32'h12345678};
    int lat;
    for (int k = 0; k < 6; k++) begin
      run_div(va[k], vb[k], vs[k], lat);
      n_tests++;
      if (lat !== 34) begin n_fail++; $display("FAIL vec%0d_latency: got %0d expected 34", k, lat); end
      n_tests++;
      if (Lo !== elo[k]) begin n_fail++; $display("FAIL vec%0d_Lo: got %h expected %h", k, Lo, elo[k]); end
      n_tests++;
      if (Hi !== ehi[k]) begin n_fail++; $display("FAIL vec%0d_Hi: got %h expected %h", k, Hi, ehi[k]); end
    end
  endtask

  task automatic test_hold_in_done();
    int  lat;
    logic seen_new;
    @(negedge clk);
    SrcA = 32'd9; SrcB = 32'd2; sign = 1'b0; validIn = 1'b1;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (validOut === 1'b1) begin lat = i - 1; break; end
    end
    n_tests++;
    if (lat !== 34) begin n_fail++; $display("FAIL hold_latency: got %0d expected 34", lat); end
    // Keep the request asserted with new operands: no new division may start.
    SrcA = 32'd1000; SrcB = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (validOut !== 1'b1 || Lo !== 32'd4 || Hi !== 32'd1) begin
        n_fail++;
        $display("FAIL hold_done%0d: got v=%b Lo=%h Hi=%h expected v=1 Lo=00000004 Hi=00000001", i, validOut, Lo, Hi);
      end
    end
    validIn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (validOut !== 1'b0) begin n_fail++; $display("FAIL hold_fall: got %b expected 0", validOut); end
    seen_new = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (validOut !== 1'b0 || Lo !== 32'd4) seen_new = 1'b1;
    end
    n_tests++;
    if (seen_new !== 1'b0) begin n_fail++; $display("FAIL hold_no_restart: got activity=%b expected 0", seen_new); end
  endtask

  task automatic test_abort();
    int   lat;
    logic seen_valid;
    run_div(32'd50, 32'd3, 1'b0, lat);
    n_tests++;
    if (Lo !== 32'd16 || Hi !== 32'd2) begin
      n_fail++; $display("FAIL abort_setup: got Lo=%h Hi=%h expected Lo=00000010 Hi=00000002", Lo, Hi);
    end
    @(negedge clk);
    SrcA = 32'd1000; SrcB = 32'd10; sign = 1'b0; validIn = 1'b1;
    repeat (10) @(negedge clk);
    validIn = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (validOut !== 1'b0) seen_valid = 1'b1;
    end
    n_tests++;
    if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL abort_validOut: got %b expected 0", seen_valid); end
    n_tests++;
    if (Lo !== 32'd16 || Hi !== 32'd2) begin
      n_fail++; $display("FAIL abort_hold: got Lo=%h Hi=%h expected Lo=00000010 Hi=00000002", Lo, Hi);
    end
    run_div(32'd100, 32'd7, 1'b0, lat);
    n_tests++;
    if (lat !== 34 || Lo !== 32'd14 || Hi !== 32'd2) begin
      n_fail++; $display("FAIL abort_next: got lat=%0d Lo=%h Hi=%h expected lat=34 Lo=0000000e Hi=00000002", lat, Lo, Hi);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    @(negedge clk);
    SrcA = 32'd1000; SrcB = 32'd10; sign = 1'b0; validIn = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (validOut !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
      n_fail++; $display("FAIL midreset_clear: got v=%b Lo=%h Hi=%h expected v=0 Lo=00000000 Hi=00000000", validOut, Lo, Hi);
    end
    reset = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (validOut === 1'b1) begin lat = i - 1; break; end
    end
    validIn = 1'b0;
    n_tests++;
    if (lat !== 34) begin n_fail++; $display("FAIL midreset_latency: got %0d expected 34", lat); end
    n_tests++;
    if (Lo !== 32'd100 || Hi !== 32'd0) begin
      n_fail++; $display("FAIL midreset_result: got Lo=%h Hi=%h expected Lo=00000064 Hi=00000000", Lo, Hi);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_vectors();
    test_hold_in_done();
    test_abort();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
